// File: rtl/voice_number_sequencer_pkg.sv
// Purpose: shared constants, state encoding and the binary-to-BCD helper for
//          the voice number sequencer.
// Contents:
//   ID_*           spoken-word IDs understood by the command FSM
//   seq_state_t    FSM state encoding (also driven out on the state port)
//   bin_to_bcd()   8-bit binary (< 100) to packed {tens, ones} BCD
package voice_number_sequencer_pkg;

  localparam logic [7:0] ID_IDLE    = 8'd0;
  localparam logic [7:0] ID_START   = 8'd5;
  localparam logic [7:0] ID_DONE    = 8'd46;
  localparam logic [7:0] ID_MORE    = 8'd47;
  localparam logic [7:0] ID_NUM_MAX = 8'd45;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  // The recognizer only produces numbers below 100, so both digits fit in 4 bits.
  function automatic logic [7:0] bin_to_bcd(input logic [7:0] value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 8'd10);
    ones = 4'(value % 8'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/seq_number_buffer.sv
// Purpose: DEPTH x 8 register file holding the recorded numbers.
// Ports:
//   i_clk          system clock
//   i_we           write enable
//   i_waddr        write index
//   i_wdata        byte to store
//   i_raddr_last   read index of the most recently recorded entry
//   i_raddr_play   read index of the entry being played back
//   o_rdata_last   async read data for i_raddr_last
//   o_rdata_play   async read data for i_raddr_play
// Contents are not reset: an entry is only read after it has been written,
// because the top level gates every read with the recorded count.
module seq_number_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr_last,
  input  logic [AW-1:0] i_raddr_play,
  output logic [7:0]    o_rdata_last,
  output logic [7:0]    o_rdata_play
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_last = r_mem[i_raddr_last];
  assign o_rdata_play = r_mem[i_raddr_play];

endmodule

// File: rtl/voice_number_sequencer.sv
// Purpose: command FSM for the voice recognizer byte stream. Records spoken
//          numbers while in START and plays them back as BCD digits in DONE.
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_reset        synchronous, active-high reset
//   i_rx_data      received ID byte
//   i_rx_valid     one-cycle strobe qualifying i_rx_data
//   o_digit_tens   BCD tens digit of the displayed number
//   o_digit_ones   BCD ones digit of the displayed number
//   o_disp_valid   digits meaningful; 0 blanks the display
//   o_state        0=IDLE 1=START 2=DONE
//   o_count        number of recorded entries
//   o_overflow     sticky: a number was dropped because the buffer was full
//   o_id_err       one-cycle pulse: ID not legal in the current state
//
// state | meaning
// IDLE  | waiting for the start word, buffer considered empty
// START | recording numbers 1..45, display shows the latest one
// DONE  | cycling through the recorded numbers, HOLD_CYCLES each
module voice_number_sequencer
  import voice_number_sequencer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic [3:0]                 o_digit_tens,
  output logic [3:0]                 o_digit_ones,
  output logic                       o_disp_valid,
  output logic [1:0]                 o_state,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic                       o_id_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int TW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [TW-1:0] C_T_END = TW'(HOLD_CYCLES - 1);

  seq_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic          r_overflow, w_overflow_nxt;
  logic          r_id_err, w_id_err_nxt;
  logic [IW-1:0] r_index, w_index_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [3:0]    r_tens, r_ones;
  logic          r_disp_valid;

  logic          w_we;
  logic          w_full;
  logic          w_last_entry;
  logic [IW-1:0] w_last_addr;
  logic [7:0]    w_rd_last, w_rd_play;
  logic [7:0]    w_disp_value;
  logic [7:0]    w_bcd;
  logic          w_disp_valid_nxt;

  assign w_full       = (r_count == C_DEPTH);
  assign w_last_addr  = IW'(r_count - CW'(1));
  // With zero or one entries the index never moves off 0.
  assign w_last_entry = (r_count <= CW'(1)) || (r_index == w_last_addr);

  seq_number_buffer #(.DEPTH(DEPTH), .AW(IW)) u_buf (
    .i_clk        (i_clk),
    .i_we         (w_we),
    .i_waddr      (r_count[IW-1:0]),
    .i_wdata      (i_rx_data),
    .i_raddr_last (w_last_addr),
    .i_raddr_play (w_index_nxt),
    .o_rdata_last (w_rd_last),
    .o_rdata_play (w_rd_play)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_id_err_nxt   = 1'b0;
    w_index_nxt    = r_index;
    w_timer_nxt    = r_timer;
    w_we           = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == ID_START)     w_state_nxt  = ST_START;
          else if (i_rx_data != ID_IDLE) w_id_err_nxt = 1'b1;
        end
      end
      ST_START: begin
        if (i_rx_valid) begin
          if (i_rx_data == ID_IDLE)      w_state_nxt = ST_IDLE;
          else if (i_rx_data == ID_DONE) w_state_nxt = ST_DONE;
          else if (i_rx_data == ID_START || i_rx_data == ID_MORE) begin
            w_state_nxt = ST_START;
          end else if (i_rx_data <= ID_NUM_MAX) begin
            if (w_full) begin
              w_overflow_nxt = 1'b1;
            end else begin
              w_we        = 1'b1;
              w_count_nxt = r_count + CW'(1);
            end
          end else begin
            w_id_err_nxt = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (i_rx_valid && i_rx_data == ID_IDLE) begin
          w_state_nxt = ST_IDLE;
        end else if (i_rx_valid && i_rx_data == ID_MORE) begin
          w_state_nxt = ST_START;
        end else begin
          // An illegal ID is flagged but does not disturb playback.
          w_id_err_nxt = i_rx_valid;
          if (r_timer == C_T_END) begin
            w_timer_nxt = '0;
            w_index_nxt = w_last_entry ? '0 : r_index + IW'(1);
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt == ST_IDLE) begin
      w_count_nxt    = '0;
      w_overflow_nxt = 1'b0;
    end
    // Playback restarts from entry 0 every time DONE is entered.
    if (w_state_nxt != ST_DONE || r_state != ST_DONE) begin
      w_index_nxt = '0;
      w_timer_nxt = '0;
    end
  end

  // Display values are derived from next-state values so the registered
  // digits change on the same edge as the state/index.
  assign w_disp_value     = (w_state_nxt == ST_START) ? (w_we ? i_rx_data : w_rd_last)
                                                      : w_rd_play;
  assign w_disp_valid_nxt = (w_state_nxt != ST_IDLE) && (w_count_nxt != '0);
  assign w_bcd            = bin_to_bcd(w_disp_value);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_id_err     <= 1'b0;
      r_index      <= '0;
      r_timer      <= '0;
      r_tens       <= '0;
      r_ones       <= '0;
      r_disp_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_overflow   <= w_overflow_nxt;
      r_id_err     <= w_id_err_nxt;
      r_index      <= w_index_nxt;
      r_timer      <= w_timer_nxt;
      r_disp_valid <= w_disp_valid_nxt;
      r_tens       <= w_disp_valid_nxt ? w_bcd[7:4] : 4'd0;
      r_ones       <= w_disp_valid_nxt ? w_bcd[3:0] : 4'd0;
    end
  end

  assign o_digit_tens = r_tens;
  assign o_digit_ones = r_ones;
  assign o_disp_valid = r_disp_valid;
  assign o_state      = r_state;
  assign o_count      = r_count;
  assign o_overflow   = r_overflow;
  assign o_id_err     = r_id_err;

endmodule

// File: tb/tb_voice_number_sequencer.sv
// Directed bench for voice_number_sequencer with DEPTH=4, HOLD_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_voice_number_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] digit_tens, digit_ones;
  logic       disp_valid;
  logic [1:0] state;
  logic [2:0] count;
  logic       overflow;
  logic       id_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  voice_number_sequencer #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_digit_tens (digit_tens),
    .o_digit_ones (digit_ones),
    .o_disp_valid (disp_valid),
    .o_state      (state),
    .o_count      (count),
    .o_overflow   (overflow),
    .o_id_err     (id_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_num(input string tag, input int value);
    chk({tag, ".tens"},  32'(digit_tens), 32'(value / 10));
    chk({tag, ".ones"},  32'(digit_ones), 32'(value % 10));
    chk({tag, ".valid"}, 32'(disp_valid), 1);
  endtask

  // Called on a falling edge; returns on the falling edge after the byte was taken.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".state"}, 32'(state), 0);
    chk({tag, ".count"}, 32'(count), 0);
    chk({tag, ".tens"},  32'(digit_tens), 0);
    chk({tag, ".ones"},  32'(digit_ones), 0);
    chk({tag, ".valid"}, 32'(disp_valid), 0);
    chk({tag, ".ovf"},   32'(overflow), 0);
    chk({tag, ".iderr"}, 32'(id_err), 0);
  endtask

  int seq1[3] = '{13, 35, 44};
  int seq2[4] = '{13, 35, 44, 30};

  initial begin
    reset    = 1'b1;
    rx_data  = 8'd0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_reset_values("rst");

    // Test 1: record 13,35,44 and play back
    send(8'd0);
    chk("t1.idle0.state", 32'(state), 0);
    chk("t1.idle0.iderr", 32'(id_err), 0);
    send(8'd5);
    chk("t1.start.state", 32'(state), 1);
    chk("t1.start.valid", 32'(disp_valid), 0);
    send(8'd13);
    chk_num("t1.rec13", 13);
    send(8'd35);
    send(8'd44);
    chk_num("t1.rec44", 44);
    chk("t1.rec.count", 32'(count), 3);
    send(8'd46);
    chk("t1.done.state", 32'(state), 2);
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk_num($sformatf("t1.play%0d.%0d", k, c), seq1[k]);
        @(negedge clk);
      end
    end
    chk_num("t1.wrap", 13);
    chk("t1.count", 32'(count), 3);

    // Test 2: append past the buffer depth
    send(8'd47);
    chk("t2.more.state", 32'(state), 1);
    chk_num("t2.more.last", 44);
    send(8'd30);
    chk_num("t2.rec30", 30);
    chk("t2.count4", 32'(count), 4);
    send(8'd38);
    chk("t2.drop.count", 32'(count), 4);
    chk("t2.drop.ovf", 32'(overflow), 1);
    chk_num("t2.drop.disp", 30);
    send(8'd46);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        chk_num($sformatf("t2.play%0d.%0d", k, c), seq2[k]);
        @(negedge clk);
      end
    end
    chk_num("t2.wrap", 13);
    chk("t2.ovf.sticky", 32'(overflow), 1);
    send(8'd12);
    chk("t2.done.iderr", 32'(id_err), 1);
    chk("t2.done.state", 32'(state), 2);

    // Test 6: ID 47 lands on the terminal timer cycle (timer now 1)
    repeat (2) @(negedge clk);
    chk_num("t6.hold", 13);
    send(8'd47);
    chk("t6.state", 32'(state), 1);
    chk_num("t6.last", 30);
    send(8'd46);
    chk_num("t6.restart", 13);

    // Test 4: leave DONE, illegal ID in IDLE
    send(8'd0);
    chk("t4.state", 32'(state), 0);
    chk("t4.count", 32'(count), 0);
    chk("t4.ovf", 32'(overflow), 0);
    chk("t4.valid", 32'(disp_valid), 0);
    send(8'd99);
    chk("t4.iderr.hi", 32'(id_err), 1);
    chk("t4.iderr.state", 32'(state), 0);
    @(negedge clk);
    chk("t4.iderr.lo", 32'(id_err), 0);

    // Test 3: DONE with nothing recorded; START illegal/ignored IDs
    send(8'd5);
    send(8'd200);
    chk("t3.start.iderr", 32'(id_err), 1);
    send(8'd47);
    chk("t3.start.ign", 32'(id_err), 0);
    chk("t3.start.state", 32'(state), 1);
    send(8'd5);
    chk("t3.start.cnt", 32'(count), 0);
    send(8'd46);
    chk("t3.done.state", 32'(state), 2);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("t3.blank%0d", c), 32'(disp_valid), 0);
      @(negedge clk);
    end
    chk("t3.count", 32'(count), 0);

    // Test 5: reset mid-record
    send(8'd0);
    send(8'd5);
    send(8'd7);
    chk_num("t5.rec7", 7);
    chk("t5.count", 32'(count), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_values("t5.rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
